// File: rtl/sram_arbiter.sv
// sram_arbiter: sole client of the SRAM controller. Merges buffered pixel
// writes from the compute engine with single-word LCD scanout reads, converts
// (x,y) to a linear framebuffer address and returns read data a fixed three
// cycles after the read is issued.
module sram_arbiter #(
  parameter int H_RES      = 480,
  parameter int V_RES      = 272,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_RD_RUN = 8
) (
  input  logic        i_CLK,
  input  logic        i_RST_N,
  input  logic        i_WrValid,
  output logic        o_WrReady,
  input  logic [9:0]  i_WrX,
  input  logic [8:0]  i_WrY,
  input  logic [15:0] i_WrColor,
  input  logic        i_RdReq,
  input  logic [18:0] i_RdAddr,
  output logic        o_RdAck,
  output logic        o_RdValid,
  output logic [15:0] o_RdData,
  output logic        o_SramBegin,
  output logic        o_SramWrite,
  output logic [18:0] o_SramAddr,
  output logic [15:0] o_SramWData,
  input  logic [15:0] i_SramData,
  input  logic        i_SramReady
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int RUN_W = $clog2(MAX_RD_RUN + 1);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(MAX_RD_RUN);
  localparam logic [9:0]       X_LIM    = 10'(H_RES);
  localparam logic [8:0]       Y_LIM    = 9'(V_RES);
  localparam logic [18:0]      LINE_W   = 19'(H_RES);

  localparam logic [0:0] S_WAIT_INIT = 1'b0;
  localparam logic [0:0] S_RUN       = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [RUN_W-1:0] run_cnt_q, run_cnt_d;
  logic             rd_vld_p1_q, rd_vld_p2_q, rd_vld_p3_q;

  logic [18:0]      fifo_addr_q  [FIFO_DEPTH];
  logic [15:0]      fifo_color_q [FIFO_DEPTH];

  logic        run;
  logic        empty;
  logic        full;
  logic        push;
  logic        in_range;
  logic        fifo_wr;
  logic        pop;
  logic [18:0] pix_addr;
  logic [18:0] head_addr;
  logic [15:0] head_color;
  logic        begin_c;
  logic        pick_wr;
  logic        wr_issue;
  logic        rd_issue;

  assign run        = (state_q == S_RUN);
  assign empty      = (count_q == '0);
  assign full       = (count_q == CNT_FULL);
  assign o_WrReady  = run & ~full;
  assign push       = i_WrValid & o_WrReady;
  assign in_range   = (i_WrX < X_LIM) & (i_WrY < Y_LIM);
  assign fifo_wr    = push & in_range;
  assign pix_addr   = 19'(i_WrY) * LINE_W + 19'(i_WrX);
  assign head_addr  = fifo_addr_q[rd_ptr_q];
  assign head_color = fifo_color_q[rd_ptr_q];

  // A write takes the slot when no read is waiting, or when reads have used up
  // their run allowance while pixels are queued.
  assign begin_c  = run & i_SramReady & (i_RdReq | ~empty);
  assign pick_wr  = ~empty & (~i_RdReq | (run_cnt_q == RUN_MAX));
  assign wr_issue = begin_c & pick_wr;
  assign rd_issue = begin_c & ~pick_wr;
  assign pop      = wr_issue;

  // Controller-facing outputs; everything is held at zero until RUN.
  always_comb begin
    o_SramBegin = 1'b0;
    o_SramWrite = 1'b0;
    o_SramAddr  = '0;
    o_SramWData = '0;
    o_RdAck     = 1'b0;
    o_RdValid   = rd_vld_p3_q;
    o_RdData    = '0;
    if (run) begin
      o_SramBegin = begin_c;
      o_SramWrite = wr_issue;
      o_RdAck     = rd_issue;
      o_RdData    = i_SramData;
      if (!empty) begin
        o_SramAddr  = head_addr;
        o_SramWData = head_color;
      end
      if (rd_issue) begin
        o_SramAddr = i_RdAddr;
      end
    end
  end

  // Next-state for the control path: FSM, FIFO pointers/count, read-run counter.
  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    run_cnt_d = run_cnt_q;

    if ((state_q == S_WAIT_INIT) && i_SramReady) begin
      state_d = S_RUN;
    end

    if (fifo_wr) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({fifo_wr, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (wr_issue || empty) begin
      run_cnt_d = '0;
    end else if (rd_issue && (run_cnt_q != RUN_MAX)) begin
      run_cnt_d = run_cnt_q + RUN_W'(1);
    end
  end

  // Control registers with synchronous active-low reset.
  always_ff @(posedge i_CLK) begin
    if (!i_RST_N) begin
      state_q     <= S_WAIT_INIT;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      run_cnt_q   <= '0;
      rd_vld_p1_q <= 1'b0;
      rd_vld_p2_q <= 1'b0;
      rd_vld_p3_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      run_cnt_q   <= run_cnt_d;
      // read issue -> controller capture two cycles later -> valid on the third
      rd_vld_p1_q <= rd_issue;
      rd_vld_p2_q <= rd_vld_p1_q;
      rd_vld_p3_q <= rd_vld_p2_q;
    end
  end

  // FIFO storage: data only, never reset; validity is tracked by count_q.
  always_ff @(posedge i_CLK) begin
    if (fifo_wr) begin
      fifo_addr_q[wr_ptr_q]  <= pix_addr;
      fifo_color_q[wr_ptr_q] <= i_WrColor;
    end
  end

endmodule
